// File: rtl/divider_unit_pkg.sv
// Shared constants for the RV32M divide unit: word width, op encodings and FSM states.
package divider_unit_pkg;

    localparam int WORD_WIDTH = 32;

    localparam logic [1:0] DIV_OP_DIV  = 2'b00;
    localparam logic [1:0] DIV_OP_DIVU = 2'b01;
    localparam logic [1:0] DIV_OP_REM  = 2'b10;
    localparam logic [1:0] DIV_OP_REMU = 2'b11;

    typedef enum logic [1:0] {
        DIV_S_IDLE = 2'b00,
        DIV_S_CALC = 2'b01,
        DIV_S_DONE = 2'b10
    } div_state_e;

endpackage

// File: rtl/divider_unit_step.sv
// One radix-2 restoring iteration: shift {rem,quo} left, conditionally subtract divisor.
module divider_unit_step #(
    parameter int W = 32
) (
    input  logic [W-1:0] rem,
    input  logic [W-1:0] quo,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] rem_next,
    output logic [W-1:0] quo_next
);

    logic [W:0] rem_sh;
    logic       ge;

    always_comb begin
        // The shifted remainder needs one extra bit before the compare.
        rem_sh   = {rem, quo[W-1]};
        ge       = (rem_sh >= {1'b0, divisor});
        rem_next = ge ? W'(rem_sh - {1'b0, divisor}) : W'(rem_sh);
        quo_next = {quo[W-2:0], ge};
    end

endmodule

// File: rtl/divider_unit.sv
// Multicycle RV32M DIV/DIVU/REM/REMU unit for the EXE stage, radix-2 restoring.
module divider_unit #(
    parameter int WORD_WIDTH = divider_unit_pkg::WORD_WIDTH,
    parameter int ITERS      = WORD_WIDTH
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  abort,
    input  logic                  div_valid,
    input  logic [1:0]            div_op,
    input  logic [WORD_WIDTH-1:0] opA,
    input  logic [WORD_WIDTH-1:0] opB,
    output logic                  div_stall,
    output logic                  div_done,
    output logic [WORD_WIDTH-1:0] div_result,
    output logic [1:0]            dbg_state
);

    import divider_unit_pkg::*;

    localparam int CW = $clog2(ITERS);
    localparam logic [WORD_WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WORD_WIDTH-1:0] MIN_NEG  = {1'b1, {(WORD_WIDTH-1){1'b0}}};
    localparam logic [CW-1:0]         LAST_CNT = CW'(ITERS - 1);

    div_state_e            state;
    logic                  op_is_rem;
    logic                  neg_quo;
    logic                  neg_rem;
    logic [WORD_WIDTH-1:0] divisor_q;
    logic [WORD_WIDTH-1:0] rem_q;
    logic [WORD_WIDTH-1:0] quo_q;
    logic [CW-1:0]         cnt_q;

    logic [WORD_WIDTH-1:0] rem_next;
    logic [WORD_WIDTH-1:0] quo_next;

    logic                  is_signed;
    logic                  a_neg;
    logic                  b_neg;
    logic                  div_by_zero;
    logic                  overflow;
    logic [WORD_WIDTH-1:0] abs_a;
    logic [WORD_WIDTH-1:0] abs_b;
    logic [WORD_WIDTH-1:0] special_res;
    logic [WORD_WIDTH-1:0] calc_res;

    divider_unit_step #(.W(WORD_WIDTH)) u_step (
        .rem      (rem_q),
        .quo      (quo_q),
        .divisor  (divisor_q),
        .rem_next (rem_next),
        .quo_next (quo_next)
    );

    always_comb begin
        is_signed   = ~div_op[0];
        a_neg       = is_signed & opA[WORD_WIDTH-1];
        b_neg       = is_signed & opB[WORD_WIDTH-1];
        abs_a       = a_neg ? -opA : opA;
        abs_b       = b_neg ? -opB : opB;
        div_by_zero = (opB == '0);
        overflow    = is_signed & (opA == MIN_NEG) & (opB == ALL_ONES);
        special_res = '0;
        case (div_op)
            DIV_OP_DIV:  special_res = div_by_zero ? ALL_ONES : MIN_NEG;
            DIV_OP_DIVU: special_res = ALL_ONES;
            DIV_OP_REM:  special_res = div_by_zero ? opA : '0;
            DIV_OP_REMU: special_res = opA;
            default:     special_res = '0;
        endcase
        calc_res = op_is_rem ? (neg_rem ? -rem_next : rem_next)
                             : (neg_quo ? -quo_next : quo_next);
    end

    // Handshake: a request is div_valid while IDLE; div_stall holds the ID/EXE
    // register from the request cycle through the last CALC cycle, and the
    // result is consumed in the single DONE cycle when div_done is high.
    assign div_stall = ((state == DIV_S_IDLE) & div_valid & ~abort) | (state == DIV_S_CALC);
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state      <= DIV_S_IDLE;
            cnt_q      <= '0;
            div_result <= '0;
            div_done   <= 1'b0;
            op_is_rem  <= 1'b0;
            neg_quo    <= 1'b0;
            neg_rem    <= 1'b0;
            divisor_q  <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
        end else begin
            div_done <= 1'b0;
            case (state)
                DIV_S_IDLE: begin
                    if (div_valid && !abort) begin
                        op_is_rem <= div_op[1];
                        neg_quo   <= (div_op == DIV_OP_DIV) & (a_neg ^ b_neg);
                        neg_rem   <= (div_op == DIV_OP_REM) & a_neg;
                        divisor_q <= abs_b;
                        rem_q     <= '0;
                        quo_q     <= abs_a;
                        cnt_q     <= '0;
                        if (div_by_zero || overflow) begin
                            div_result <= special_res;
                            div_done   <= 1'b1;
                            state      <= DIV_S_DONE;
                        end else begin
                            state <= DIV_S_CALC;
                        end
                    end
                end
                DIV_S_CALC: begin
                    if (abort) begin
                        state <= DIV_S_IDLE;
                    end else begin
                        rem_q <= rem_next;
                        quo_q <= quo_next;
                        cnt_q <= cnt_q + CW'(1);
                        if (cnt_q == LAST_CNT) begin
                            div_result <= calc_res;
                            div_done   <= 1'b1;
                            state      <= DIV_S_DONE;
                        end
                    end
                end
                DIV_S_DONE: state <= DIV_S_IDLE;
                default:    state <= DIV_S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_divider_unit.sv
// Self-checking bench for divider_unit: vector table, corner sequences, random vs reference model.
module tb_divider_unit;

    import divider_unit_pkg::*;

    logic        clk = 1'b0;
    logic        nrst;
    logic        abort;
    logic        div_valid;
    logic [1:0]  div_op;
    logic [31:0] opA;
    logic [31:0] opB;
    logic        div_stall;
    logic        div_done;
    logic [31:0] div_result;
    logic [1:0]  dbg_state;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_res;
        int          exp_lat;
        int          exp_stalls;
    } vec_t;

    vec_t vecs[16];

    divider_unit dut (
        .clk        (clk),
        .nrst       (nrst),
        .abort      (abort),
        .div_valid  (div_valid),
        .div_op     (div_op),
        .opA        (opA),
        .opB        (opB),
        .div_stall  (div_stall),
        .div_done   (div_done),
        .div_result (div_result),
        .dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain integer division with the RISC-V rules for zero divisor.
    function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        if (op[0]) begin
            sa = longint'(a);
            sb = longint'(b);
        end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end
        q = sa / sb;
        r = sa % sb;
        return op[1] ? r[31:0] : q[31:0];
    endfunction

    function automatic int ref_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return 1;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Issue one request from an IDLE cycle; returns result, cycles to div_done and stall count.
    // Ends in the IDLE cycle after DONE. Operands are scrambled after capture.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat, output int stalls);
        div_valid = 1'b1;
        div_op    = op;
        opA       = a;
        opB       = b;
        lat       = -1;
        stalls    = 0;
        res       = 32'hDEAD_BEEF;
        #1;
        for (int c = 0; c < 100; c++) begin
            if (div_stall) stalls++;
            if (div_done) begin
                lat = c;
                res = div_result;
                break;
            end
            cycle();
            if (c == 0) begin
                div_valid = 1'b0;
                opA       = $urandom;
                opB       = $urandom;
            end
        end
        div_valid = 1'b0;
        cycle();
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'($urandom_range(0, 1000));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] res;
        int lat, stalls, n, p1, p2;

        vecs[0]  = '{DIV_OP_DIVU, 32'd100,        32'd7,          32'h0000_000E, 33, 33};
        vecs[1]  = '{DIV_OP_REMU, 32'd100,        32'd7,          32'h0000_0002, 33, 33};
        vecs[2]  = '{DIV_OP_DIV,  32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2, 33, 33};
        vecs[3]  = '{DIV_OP_REM,  32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFFE, 33, 33};
        vecs[4]  = '{DIV_OP_REM,  32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'hFFFF_FFFE, 33, 33};
        vecs[5]  = '{DIV_OP_DIV,  32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'h0000_000E, 33, 33};
        vecs[6]  = '{DIV_OP_DIV,  32'h1234_5678,  32'd0,          32'hFFFF_FFFF, 1,  1};
        vecs[7]  = '{DIV_OP_REMU, 32'h1234_5678,  32'd0,          32'h1234_5678, 1,  1};
        vecs[8]  = '{DIV_OP_DIVU, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF, 1,  1};
        vecs[9]  = '{DIV_OP_REM,  32'h1234_5678,  32'd0,          32'h1234_5678, 1,  1};
        vecs[10] = '{DIV_OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000, 1,  1};
        vecs[11] = '{DIV_OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000, 1,  1};
        vecs[12] = '{DIV_OP_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000, 33, 33};
        vecs[13] = '{DIV_OP_REMU, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000, 33, 33};
        vecs[14] = '{DIV_OP_DIV,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD, 33, 33};
        vecs[15] = '{DIV_OP_REM,  32'd7,          32'hFFFF_FFFE,  32'h0000_0001, 33, 33};

        // Clock/reset
        nrst      = 1'b0;
        abort     = 1'b0;
        div_valid = 1'b0;
        div_op    = 2'b00;
        opA       = '0;
        opB       = '0;
        cycle();
        cycle();
        check("rst_result", div_result, 32'd0);
        check("rst_done", 32'(div_done), 32'd0);
        check("rst_stall_idle", 32'(div_stall), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(DIV_S_IDLE));
        div_valid = 1'b1;
        #1;
        check("rst_stall_valid", 32'(div_stall), 32'd1);
        div_valid = 1'b0;
        cycle();
        nrst = 1'b1;
        cycle();

        // Table
        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, lat, stalls);
            check($sformatf("vec%0d_res", i), res, vecs[i].exp_res);
            check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
            check($sformatf("vec%0d_stall", i), 32'(stalls), 32'(vecs[i].exp_stalls));
        end

        // Abort mid-CALC: result register keeps the prior value
        run_op(DIV_OP_DIVU, 32'd50, 32'd5, res, lat, stalls);
        check("pre_abort_res", res, 32'd10);
        div_valid = 1'b1;
        div_op    = DIV_OP_DIVU;
        opA       = 32'd1000;
        opB       = 32'd3;
        cycle();
        div_valid = 1'b0;
        n = 0;
        for (int c = 1; c < 10; c++) begin
            if (div_done) n++;
            cycle();
        end
        abort = 1'b1;
        if (div_done) n++;
        cycle();
        abort = 1'b0;
        if (div_done) n++;
        check("abort_no_done", 32'(n), 32'd0);
        check("abort_state", 32'(dbg_state), 32'(DIV_S_IDLE));
        check("abort_stall", 32'(div_stall), 32'd0);
        check("abort_result_held", div_result, 32'd10);
        cycle();
        run_op(DIV_OP_DIVU, 32'd1000, 32'd3, res, lat, stalls);
        check("post_abort_res", res, 32'd333);
        check("post_abort_lat", 32'(lat), 32'd33);

        // Reset during an operation
        div_valid = 1'b1;
        div_op    = DIV_OP_DIVU;
        opA       = 32'd1000;
        opB       = 32'd3;
        cycle();
        div_valid = 1'b0;
        for (int c = 1; c < 5; c++) cycle();
        nrst = 1'b0;
        cycle();
        check("midrst_result", div_result, 32'd0);
        check("midrst_state", 32'(dbg_state), 32'(DIV_S_IDLE));
        check("midrst_done", 32'(div_done), 32'd0);
        nrst = 1'b1;
        cycle();

        // Back-to-back with div_valid held high
        div_valid = 1'b1;
        div_op    = DIV_OP_DIVU;
        opA       = 32'd1000;
        opB       = 32'd3;
        n  = 0;
        p1 = -1;
        p2 = -1;
        #1;
        for (int c = 0; c < 90; c++) begin
            if (div_done) begin
                check($sformatf("b2b_res%0d", n), div_result, 32'd333);
                if (n == 0) p1 = c;
                else p2 = c;
                n++;
                if (n == 2) begin
                    div_valid = 1'b0;
                    break;
                end
            end
            cycle();
        end
        div_valid = 1'b0;
        cycle();
        check("b2b_count", 32'(n), 32'd2);
        check("b2b_first", 32'(p1), 32'd33);
        check("b2b_gap", 32'(p2 - p1), 32'd34);

        // Random against the reference model
        for (int k = 0; k < 40; k++) begin
            logic [1:0]  op;
            logic [31:0] a, b;
            op = 2'($urandom_range(0, 3));
            a  = pick_operand();
            b  = pick_operand();
            exp_q.push_back(ref_div(op, a, b));
            run_op(op, a, b, res, lat, stalls);
            check($sformatf("rand%0d_res op=%0d a=%h b=%h", k, op, a, b), res, exp_q.pop_front());
            check($sformatf("rand%0d_lat", k), 32'(lat), 32'(ref_lat(op, a, b)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/divider_unit.md
# divider_unit

Multicycle RV32M divide/remainder responder in the EXE stage. It accepts the `div_valid`/`div_op` request and the forwarded operands that the ID/EXE pipeline register delivers. It holds the pipeline with `div_stall` while the iterative quotient is computed, then presents the result for one cycle. It covers DIV, DIVU, REM and REMU using a radix-2 restoring algorithm.

## Interface
- `WORD_WIDTH`, default 32: operand and result width, from `constants.vh`.
- `ITERS`, default 32: iteration count; must equal `WORD_WIDTH`.
- `clk`  in  1  clock.
- `nrst`  in  1  reset, synchronous, active-low.
- `abort`  in  1  synchronous cancel of an in-flight operation (pipeline flush of EXE).
- `div_valid`  in  1  request; meaningful only while the unit is in IDLE.
- `div_op`  in  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- `opA`  in  `WORD_WIDTH`  dividend.
- `opB`  in  `WORD_WIDTH`  divisor.
- `div_stall`  out  1  pipeline hold request.
- `div_done`  out  1  single-cycle completion strobe.
- `div_result`  out  `WORD_WIDTH`  quotient or remainder.

## Operation
- **States:** IDLE, CALC, DONE.
- **IDLE:**
  - On `div_valid`=1 and `abort`=0, capture `div_op`, the signs, |opA| and |opB|. Signed ops take absolute values; unsigned ops take the operands raw.
  - If `opB`=0, or if the op is signed with `opA`=0x80000000 and `opB`=0xFFFFFFFF, go directly to DONE with the special result.
  - Otherwise clear the remainder accumulator, load the quotient shift register with the dividend, clear the iteration counter, and go to CALC.
- **CALC, one step per cycle:**
  - Form `{rem,quo}` shifted left by 1.
  - If `rem` ≥ divisor, subtract the divisor and set `quo[0]`=1.
  - The counter increments each step. After the step with counter = `ITERS`-1, go to DONE.
- **Sign fix, applied on entry to DONE:**
  - The quotient is negated when the op is DIV and the operand signs differ.
  - The remainder is negated when the op is REM and the dividend is negative.
- **Special results:**
  - Divide-by-zero: DIV/DIVU → 0xFFFFFFFF; REM/REMU → `opA`.
  - Signed overflow: DIV → 0x80000000; REM → 0.
- **DONE:** `div_done`=1 for exactly one cycle, then return to IDLE unconditionally.
- **Result register:** `div_result` is registered. It holds its value after DONE until the next completion.
- **`div_stall`:** combinational, `(IDLE & div_valid & ~abort) | CALC`. It is low in DONE, so the pipeline advances at the end of the DONE cycle.
- **`div_valid` still high after DONE:** it belongs to the next instruction and starts a new operation.
- **`abort`:** in CALC or DONE, go to IDLE at the next edge; `div_done` stays 0 and `div_result` is unchanged. In IDLE, `abort` blocks capture.
- **Reset:** state IDLE, counter 0, `div_result` 0, `div_done` 0. `div_stall` follows its equation, so it is 0 unless `div_valid` is high. Reset takes priority over `abort` and over an operation in progress.

## Timing
- **Normal operation:** request sampled at edge T.
  - CALC occupies cycles T+1..T+32.
  - DONE is cycle T+33, with `div_done`=1 and `div_result` valid.
  - `div_stall` is high during cycles T..T+32 (33 cycles).
- **Special cases:** DONE is at T+1 and `div_stall` is high for cycle T only.
- **Back-to-back:** a new request can be accepted in the cycle after DONE, with no dead cycle beyond DONE itself.
- **Operand sampling:** operands are sampled only at the capture edge. Changes to `opA`/`opB` during CALC are ignored.

## Structure
- **Shared in `constants.vh`:**
  - `WORD_WIDTH`.
  - `DIV_OP_DIV`=2'b00, `DIV_OP_DIVU`=2'b01, `DIV_OP_REM`=2'b10, `DIV_OP_REMU`=2'b11.
  - State encodings `DIV_S_IDLE`/`DIV_S_CALC`/`DIV_S_DONE`.
- **Optional sub-module:** `div_step`, a combinational compare/subtract/shift for one iteration, which keeps the FSM file small.
- **Counter width:** `$clog2(ITERS)` bits.

## Test plan
- DIVU `opA`=100, `opB`=7 → `div_done` at T+33, result 14; REMU with the same operands → 2; `div_stall` high for exactly 33 cycles.
- DIV `opA`=-100 (0xFFFFFF9C), `opB`=7 → 0xFFFFFFF2 (-14); REM with the same operands → 0xFFFFFFFE (-2); REM -100 / -7 → -2.
- DIV `opB`=0, `opA`=0x12345678 → result 0xFFFFFFFF at T+1; REMU with the same operands → 0x12345678; stall high for one cycle only.
- DIV 0x80000000 / 0xFFFFFFFF → 0x80000000 at T+1; REM with the same operands → 0.
- Start DIVU 1000/3, assert `abort` at T+10 → IDLE at T+11, no `div_done`, `div_result` still holds the prior value; a new request at T+12 completes normally.
- Assert `nrst`=0 at T+5 of an operation → `div_result`=0 and state IDLE after the edge; `div_valid` held high for two back-to-back operations → two `div_done` pulses 34 cycles apart.
